// File: rtl/writeback_arbiter.sv
// ============================================================================
// writeback_arbiter : merges MEM/WB results and queued MDU results onto the
// single register-file write port. Rev 1.0
// ============================================================================
`default_nettype none

module writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wb_valid,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_dest,
    input  logic             wb_memtoreg,
    input  logic [31:0]      wb_alu_result,
    input  logic [31:0]      wb_mem_data,
    input  logic             mdu_valid,
    input  logic [4:0]       mdu_dest,
    input  logic [31:0]      mdu_data,
    output logic             mdu_ready,
    output logic [4:0]       reg_write,
    output logic             regwrite_con,
    output logic [31:0]      write_data,
    output logic [31:0]      pending_mask,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int               PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [4:0]       dest_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       reg_write_q, reg_write_d;
    logic             regwrite_con_q, regwrite_con_d;
    logic [31:0]      write_data_q, write_data_d;

    logic pipe_wr;
    logic push;
    logic pop;

    assign pipe_wr   = wb_valid & wb_regwrite & (wb_dest != 5'd0);
    assign mdu_ready = reset_n & (count_q < C_FULL);
    // A result for the register the pipe is writing right now is already stale.
    assign push      = mdu_valid & mdu_ready & (mdu_dest != 5'd0)
                       & ~(pipe_wr & (mdu_dest == wb_dest));
    assign pop       = ~pipe_wr & (count_q != '0);

    always_comb begin
        live_d         = live_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        reg_write_d    = reg_write_q;
        write_data_d   = write_data_q;
        regwrite_con_d = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_wr && live_q[i] && (dest_q[i] == wb_dest)) begin
                live_d[i] = 1'b0;
            end
        end

        if (pipe_wr) begin
            reg_write_d    = wb_dest;
            regwrite_con_d = 1'b1;
            write_data_d   = wb_memtoreg ? wb_mem_data : wb_alu_result;
        end else if (pop) begin
            if (live_q[head_q]) begin
                reg_write_d    = dest_q[head_q];
                regwrite_con_d = 1'b1;
                write_data_d   = data_q[head_q];
            end
            live_d[head_q] = 1'b0;
            head_d         = head_q + PTR_W'(1);
        end

        if (push) begin
            live_d[tail_q] = 1'b1;
            tail_d         = tail_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pending_mask[dest_q[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            live_q         <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            reg_write_q    <= '0;
            regwrite_con_q <= 1'b0;
            write_data_q   <= '0;
        end else begin
            live_q         <= live_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            reg_write_q    <= reg_write_d;
            regwrite_con_q <= regwrite_con_d;
            write_data_q   <= write_data_d;
        end
    end

    // Payload storage needs no reset: live bits gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[tail_q] <= mdu_dest;
            data_q[tail_q] <= mdu_data;
        end
    end

    assign reg_write    = reg_write_q;
    assign regwrite_con = regwrite_con_q;
    assign write_data   = write_data_q;
    assign fifo_count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// ============================================================================
// tb_writeback_arbiter : directed self-checking bench for writeback_arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_writeback_arbiter;

    logic        clk;
    logic        reset_n;
    logic        wb_valid, wb_regwrite, wb_memtoreg;
    logic [4:0]  wb_dest;
    logic [31:0] wb_alu_result, wb_mem_data;
    logic        mdu_valid;
    logic [4:0]  mdu_dest;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [4:0]  reg_write;
    logic        regwrite_con;
    logic [31:0] write_data;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;

    int n_cmp = 0;
    int n_err = 0;

    writeback_arbiter #(.DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_dest(wb_dest),
        .wb_memtoreg(wb_memtoreg), .wb_alu_result(wb_alu_result),
        .wb_mem_data(wb_mem_data),
        .mdu_valid(mdu_valid), .mdu_dest(mdu_dest), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready), .reg_write(reg_write),
        .regwrite_con(regwrite_con), .write_data(write_data),
        .pending_mask(pending_mask), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic v, input logic [4:0] d, input logic m2r,
                        input logic [31:0] alu, input logic [31:0] mem);
        wb_valid      = v;
        wb_regwrite   = v;
        wb_dest       = d;
        wb_memtoreg   = m2r;
        wb_alu_result = alu;
        wb_mem_data   = mem;
    endtask

    task automatic mdu(input logic v, input logic [4:0] d, input logic [31:0] x);
        mdu_valid = v;
        mdu_dest  = d;
        mdu_data  = x;
    endtask

    task automatic port(input string tag, input logic [4:0] rw, input logic con,
                        input logic [31:0] wd);
        check({tag, ".reg_write"}, {27'd0, reg_write}, {27'd0, rw});
        check({tag, ".con"}, {31'd0, regwrite_con}, {31'd0, con});
        check({tag, ".data"}, write_data, wd);
    endtask

    initial begin
        reset_n = 1'b0;
        pipe(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        mdu(1'b0, 5'd0, 32'd0);
        #3;
        port("rst", 5'd0, 1'b0, 32'd0);
        check("rst.mask", pending_mask, 32'd0);
        check("rst.count", {29'd0, fifo_count}, 32'd0);
        check("rst.ready", {31'd0, mdu_ready}, 32'd0);
        step();
        step();
        reset_n = 1'b1;
        #1;
        check("rel.ready", {31'd0, mdu_ready}, 32'd1);

        // Basic pipe writes
        pipe(1'b1, 5'd8, 1'b0, 32'h3E8, 32'h0);
        step();
        port("t1", 5'd8, 1'b1, 32'h3E8);
        pipe(1'b1, 5'd9, 1'b1, 32'hFFFF, 32'h2);
        step();
        port("t2", 5'd9, 1'b1, 32'h2);
        pipe(1'b1, 5'd0, 1'b0, 32'h55, 32'h66);
        step();
        port("t2.r0", 5'd9, 1'b0, 32'h2);

        // MDU result queued behind a busy pipe
        pipe(1'b1, 5'd5, 1'b0, 32'h1, 32'h0);
        mdu(1'b1, 5'd10, 32'hDEAD);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        port("t3.pipe", 5'd5, 1'b1, 32'h1);
        check("t3.mask", pending_mask, 32'h400);
        check("t3.count", {29'd0, fifo_count}, 32'd1);
        pipe(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        step();
        port("t3.pop", 5'd10, 1'b1, 32'hDEAD);
        check("t3.mask0", pending_mask, 32'd0);
        check("t3.count0", {29'd0, fifo_count}, 32'd0);

        // Fill to full across pointer wrap, then drain in order
        pipe(1'b1, 5'd5, 1'b0, 32'h1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("t4.ready_in", {31'd0, mdu_ready}, 32'd1);
            mdu(1'b1, 5'(11 + i), 32'hA0 + i);
            step();
        end
        check("t4.count4", {29'd0, fifo_count}, 32'd4);
        check("t4.ready0", {31'd0, mdu_ready}, 32'd0);
        check("t4.mask", pending_mask, 32'h0000_7800);
        pipe(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        mdu(1'b1, 5'd15, 32'hBAD);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        port("t4.pop0", 5'd11, 1'b1, 32'hA0);
        check("t4.count3", {29'd0, fifo_count}, 32'd3);
        check("t4.ready1", {31'd0, mdu_ready}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            port("t4.pop", 5'(11 + i), 1'b1, 32'hA0 + i);
        end
        check("t4.empty", {29'd0, fifo_count}, 32'd0);
        step();
        port("t4.idle", 5'd14, 1'b0, 32'hA3);

        // Squash by a younger pipe write
        pipe(1'b1, 5'd5, 1'b0, 32'h1, 32'h0);
        mdu(1'b1, 5'd10, 32'hDEAD);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        pipe(1'b1, 5'd10, 1'b0, 32'h7, 32'h0);
        step();
        port("t5.pipe", 5'd10, 1'b1, 32'h7);
        check("t5.mask", pending_mask, 32'd0);
        check("t5.count1", {29'd0, fifo_count}, 32'd1);
        pipe(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        step();
        port("t5.sqpop", 5'd10, 1'b0, 32'h7);
        check("t5.count0", {29'd0, fifo_count}, 32'd0);

        // Same-cycle collision and dest 0 are accepted but dropped
        pipe(1'b1, 5'd12, 1'b0, 32'h12, 32'h0);
        mdu(1'b1, 5'd12, 32'hC0C0);
        check("t5.ready_col", {31'd0, mdu_ready}, 32'd1);
        step();
        check("t5.collide", {29'd0, fifo_count}, 32'd0);
        mdu(1'b1, 5'd0, 32'h1234);
        step();
        check("t5.dest0", {29'd0, fifo_count}, 32'd0);
        check("t5.dest0mask", pending_mask, 32'd0);

        // Simultaneous push and pop keeps the count
        pipe(1'b1, 5'd5, 1'b0, 32'h1, 32'h0);
        mdu(1'b1, 5'd20, 32'h20);
        step();
        pipe(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        mdu(1'b1, 5'd21, 32'h21);
        step();
        mdu(1'b0, 5'd0, 32'd0);
        port("t5b.pop", 5'd20, 1'b1, 32'h20);
        check("t5b.count", {29'd0, fifo_count}, 32'd1);
        check("t5b.mask", pending_mask, 32'h0020_0000);
        step();
        port("t5b.pop2", 5'd21, 1'b1, 32'h21);
        check("t5b.count0", {29'd0, fifo_count}, 32'd0);

        // Asynchronous reset mid-operation
        pipe(1'b1, 5'd5, 1'b0, 32'h1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            mdu(1'b1, 5'(1 + i), 32'h10 + i);
            step();
        end
        mdu(1'b0, 5'd0, 32'd0);
        pipe(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
        check("t6.count3", {29'd0, fifo_count}, 32'd3);
        check("t6.con1", {31'd0, regwrite_con}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        port("t6.rst", 5'd0, 1'b0, 32'd0);
        check("t6.rst.count", {29'd0, fifo_count}, 32'd0);
        check("t6.rst.mask", pending_mask, 32'd0);
        check("t6.rst.ready", {31'd0, mdu_ready}, 32'd0);
        step();
        #3;
        reset_n = 1'b1;
        step();
        check("t6.rel.count", {29'd0, fifo_count}, 32'd0);
        check("t6.rel.ready", {31'd0, mdu_ready}, 32'd1);
        check("t6.rel.con", {31'd0, regwrite_con}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
